// File: rtl/ocimem_pkg.sv
// Shared definitions for the OCI-memory arbiter.
//   state_t    : arbiter FSM states
//   jtag_op_t  : access kind (used for both the JTAG pending slot and the latched access)
//   JDO_*      : bit positions of the fields carried in the JTAG jdo payload
//   GRANT_*    : encoding of the round-robin last_grant register
package ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } jtag_op_t;

    localparam int JDO_ADDR_LSB  = 2;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_RDREQ     = 35;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_JTAG = 1'b1;

endpackage

// File: rtl/nios_system_nios2_gen_0_cpu_ocimem_rr_arb.sv
// Two-way round-robin arbiter between the JTAG command path and the CPU.
//   clk, reset : clock and async active-high reset (last_grant resets to CPU)
//   en         : grants are only issued while enabled (FSM idle)
//   req_jtag   : JTAG command waiting
//   req_cpu    : CPU read or write request
//   gnt_jtag   : JTAG wins this cycle
//   gnt_cpu    : CPU wins this cycle
module nios_system_nios2_gen_0_cpu_ocimem_rr_arb
    import ocimem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_jtag,
    input  logic req_cpu,
    output logic gnt_jtag,
    output logic gnt_cpu
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_jtag     = 1'b0;
        gnt_cpu      = 1'b0;
        last_grant_d = last_grant_q;
        if (en) begin
            if (req_jtag && req_cpu) begin
                // Contention: the side that did not win last time goes first.
                gnt_jtag = (last_grant_q == GRANT_CPU);
                gnt_cpu  = (last_grant_q == GRANT_JTAG);
            end else begin
                gnt_jtag = req_jtag;
                gnt_cpu  = req_cpu;
            end
        end
        if (gnt_jtag) begin
            last_grant_d = GRANT_JTAG;
        end else if (gnt_cpu) begin
            last_grant_d = GRANT_CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_CPU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/nios_system_nios2_gen_0_cpu_ocimem_arbiter.sv
// Shares the single-port debug RAM between JTAG OCI-memory commands and CPU debug accesses.
//   clk, reset                : clock, async active-high reset
//   jdo, take_*_ocimem_*      : JTAG command payload and strobes
//   cpu_*                     : CPU debug slave (waitrequest handshake)
//   ram_*                     : debug RAM port (1-cycle read latency)
//   MonDReg                   : last JTAG read result
//   monitor_ready             : no JTAG command pending
//   monitor_error             : sticky, a JTAG strobe was dropped
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrate JTAG vs CPU, latch address/data/byte-enables/op
// ST_ACCESS  | drive the RAM strobes from latched values; writes finish
// ST_CAPTURE | RAM data valid; route to MonDReg or cpu_readdata; reads finish
module nios_system_nios2_gen_0_cpu_ocimem_arbiter
    import ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_t              state_q, state_d;
    jtag_op_t            pend_op_q, pend_op_d;
    logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;
    logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
    logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
    logic                mon_err_q, mon_err_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [3:0]          lat_be_q, lat_be_d;
    jtag_op_t            lat_op_q, lat_op_d;
    logic                lat_jtag_q, lat_jtag_d;

    jtag_op_t            strobe_op;
    jtag_op_t            jtag_req_op;
    logic                jtag_done;
    logic                slot_free;
    logic                accept;
    logic [ADDR_W-1:0]   jtag_cmd_addr;
    logic [DATA_W-1:0]   jtag_cmd_wdata;
    logic                gnt_jtag, gnt_cpu;
    logic                unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    nios_system_nios2_gen_0_cpu_ocimem_rr_arb u_rr_arb (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == ST_IDLE),
        .req_jtag (jtag_req_op != OP_NONE),
        .req_cpu  (cpu_read || cpu_write),
        .gnt_jtag (gnt_jtag),
        .gnt_cpu  (gnt_cpu)
    );

    // JTAG command intake: one pending slot, refilled in the cycle it completes.
    always_comb begin
        strobe_op = OP_NONE;
        if (take_action_ocimem_a) begin
            strobe_op = jdo[JDO_RDREQ] ? OP_RD : OP_NONE;
        end else if (take_no_action_ocimem_a) begin
            strobe_op = OP_RD;
        end else if (take_action_ocimem_b) begin
            strobe_op = OP_WR;
        end

        jtag_done = lat_jtag_q &&
                    (((state_q == ST_ACCESS) && (lat_op_q == OP_WR)) || (state_q == ST_CAPTURE));
        slot_free = (pend_op_q == OP_NONE) || jtag_done;
        accept    = (strobe_op != OP_NONE) && slot_free;

        pend_op_d    = pend_op_q;
        pend_wdata_d = pend_wdata_q;
        if (jtag_done) begin
            pend_op_d = OP_NONE;
        end
        if (accept) begin
            pend_op_d    = strobe_op;
            pend_wdata_d = jdo[JDO_WDATA_LSB +: DATA_W];
        end

        // Address load wins over the post-increment of a completing command.
        jtag_addr_d = jtag_addr_q;
        if (jtag_done) begin
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        end
        if (take_action_ocimem_a) begin
            jtag_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
        end

        mon_err_d = mon_err_q;
        if ((strobe_op != OP_NONE) && !slot_free) begin
            mon_err_d = 1'b1;
        end else if (take_action_ocimem_a && slot_free) begin
            mon_err_d = 1'b0;
        end

        // A strobe arriving while idle competes immediately instead of waiting a cycle.
        if (pend_op_q != OP_NONE) begin
            jtag_req_op    = pend_op_q;
            jtag_cmd_addr  = jtag_addr_q;
            jtag_cmd_wdata = pend_wdata_q;
        end else begin
            jtag_req_op    = accept ? strobe_op : OP_NONE;
            jtag_cmd_addr  = jtag_addr_d;
            jtag_cmd_wdata = jdo[JDO_WDATA_LSB +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_be_d    = lat_be_q;
        lat_op_d    = lat_op_q;
        lat_jtag_d  = lat_jtag_q;
        mon_dreg_d  = mon_dreg_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_jtag) begin
                    lat_addr_d  = jtag_cmd_addr;
                    lat_wdata_d = jtag_cmd_wdata;
                    lat_be_d    = 4'hF;
                    lat_op_d    = jtag_req_op;
                    lat_jtag_d  = 1'b1;
                    state_d     = ST_ACCESS;
                end else if (gnt_cpu) begin
                    lat_addr_d  = cpu_address;
                    lat_wdata_d = cpu_writedata;
                    lat_be_d    = cpu_byteenable;
                    lat_op_d    = cpu_write ? OP_WR : OP_RD;
                    lat_jtag_d  = 1'b0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = (lat_op_q == OP_WR) ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (lat_jtag_q) begin
                    mon_dreg_d = ram_rdata;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pend_op_q    <= OP_NONE;
            pend_wdata_q <= '0;
            jtag_addr_q  <= '0;
            mon_dreg_q   <= '0;
            mon_err_q    <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_be_q     <= '0;
            lat_op_q     <= OP_NONE;
            lat_jtag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_op_q    <= pend_op_d;
            pend_wdata_q <= pend_wdata_d;
            jtag_addr_q  <= jtag_addr_d;
            mon_dreg_q   <= mon_dreg_d;
            mon_err_q    <= mon_err_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_be_q     <= lat_be_d;
            lat_op_q     <= lat_op_d;
            lat_jtag_q   <= lat_jtag_d;
        end
    end

    // RAM strobes are decoded from the state so an async reset kills them at once.
    assign ram_addr        = lat_addr_q;
    assign ram_wdata       = lat_wdata_q;
    assign ram_be          = lat_be_q;
    assign ram_we          = (state_q == ST_ACCESS) && (lat_op_q == OP_WR);
    assign ram_re          = (state_q == ST_ACCESS) && (lat_op_q == OP_RD);
    assign cpu_readdata    = ((state_q == ST_CAPTURE) && !lat_jtag_q) ? ram_rdata : '0;
    assign cpu_waitrequest = !(!lat_jtag_q &&
                               (((state_q == ST_ACCESS) && (lat_op_q == OP_WR)) ||
                                (state_q == ST_CAPTURE)));
    assign MonDReg         = mon_dreg_q;
    assign monitor_ready   = (pend_op_q == OP_NONE);
    assign monitor_error   = mon_err_q;

endmodule

// File: tb/tb_nios_system_nios2_gen_0_cpu_ocimem_arbiter.sv
module tb_nios_system_nios2_gen_0_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int checks = 0;
    int errors = 0;

    // Debug RAM seen by the DUT, and the reference memory/pointer kept by the bench.
    logic [31:0] ram [256];
    logic [31:0] mdl [256];
    logic [7:0]  mja;

    always #5 clk = ~clk;

    nios_system_nios2_gen_0_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_we                  (ram_we),
        .ram_re                  (ram_re),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j       = '0;
        j[9:2]  = a;
        j[35]   = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // kind: 0 = ocimem_a, 1 = stream read, 2 = ocimem_b
    task automatic strobe(input int kind, input logic [37:0] j);
        jdo                     = j;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        jdo                     = '0;
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!monitor_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, (n < 20), 1'b1);
    endtask

    task automatic jtag_write(input string tag, input logic [31:0] d);
        int n;
        strobe(2, jdo_b(d));
        check({tag, "_busy"}, monitor_ready, 1'b0);
        wait_ready(tag, n);
        check({tag, "_wr_lat"}, n, 1);
        mdl[mja] = d;
        check({tag, "_ram"}, ram[mja], mdl[mja]);
        mja++;
    endtask

    task automatic jtag_read_a(input string tag, input logic [7:0] a);
        int n;
        mja = a;
        strobe(0, jdo_a(a, 1'b1));
        check({tag, "_busy"}, monitor_ready, 1'b0);
        wait_ready(tag, n);
        check({tag, "_rd_lat"}, n, 2);
        check({tag, "_mondreg"}, MonDReg, mdl[a]);
        mja++;
    endtask

    task automatic jtag_stream(input string tag);
        int n;
        strobe(1, '0);
        wait_ready(tag, n);
        check({tag, "_mondreg"}, MonDReg, mdl[mja]);
        mja++;
    endtask

    task automatic jtag_load(input string tag, input logic [7:0] a);
        strobe(0, jdo_a(a, 1'b0));
        check({tag, "_ready_kept"}, monitor_ready, 1'b1);
        mja = a;
    endtask

    task automatic cpu_access(input string tag, input logic we, input logic [7:0] a,
                              input logic [31:0] d, input logic [3:0] be, input int exp_lat);
        int n;
        logic [31:0] old;
        old            = mdl[a];
        cpu_address    = a;
        cpu_writedata  = d;
        cpu_byteenable = be;
        cpu_write      = we;
        cpu_read       = !we;
        n = 0;
        while (cpu_waitrequest && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        if (!we) check({tag, "_rdata"}, cpu_readdata, old);
        tick();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        if (we) mdl[a] = merge(old, d, be);
        check({tag, "_ram"}, ram[a], mdl[a]);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        logic [7:0]  a;

        for (int i = 0; i < 256; i++) begin
            v      = $urandom;
            ram[i] = v;
            mdl[i] = v;
        end
        ram_rdata = '0;
        jdo = '0;
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
        mja = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", monitor_ready, 1'b1);
        check("rst_error", monitor_error, 1'b0);
        check("rst_we_re", {ram_we, ram_re}, 2'b00);
        check("rst_waitreq", cpu_waitrequest, 1'b1);

        // Address load then JTAG write.
        jtag_load("t1_load", 8'h10);
        jtag_write("t1_wr", 32'hDEADBEEF);
        check("t1_ram_const", ram[8'h10], 32'hDEADBEEF);
        check("t1_jaddr", dut.jtag_addr_q, 8'h11);
        check("t1_error", monitor_error, 1'b0);

        // Address load with read.
        jtag_read_a("t2", 8'h10);
        check("t2_mon_const", MonDReg, 32'hDEADBEEF);
        check("t2_jaddr", dut.jtag_addr_q, 8'h11);

        // CPU read then partial write.
        cpu_access("t3_rd", 1'b0, 8'h10, 32'h0, 4'hF, 2);
        cpu_access("t3_wr", 1'b1, 8'h10, 32'h12345678, 4'b0011, 1);
        check("t3_ram_const", ram[8'h10], 32'hDEAD5678);

        // Contention after a JTAG grant: CPU goes first and sees the old data.
        jtag_write("t4b_pre", 32'h0BADF00D);
        a = mja;
        v = mdl[a];
        cpu_address = a; cpu_read = 1'b1; cpu_byteenable = 4'hF;
        strobe(2, jdo_b(32'hC0FFEE11));
        n = 1;
        while (cpu_waitrequest && n < 20) begin tick(); n++; end
        check("t4b_cpu_lat", n, 2);
        check("t4b_cpu_old", cpu_readdata, v);
        tick();
        cpu_read = 1'b0;
        check("t4b_busy", monitor_ready, 1'b0);
        wait_ready("t4b", n);
        mdl[a] = 32'hC0FFEE11;
        check("t4b_ram", ram[a], mdl[a]);
        mja++;

        // Wrap and dropped strobe.
        jtag_load("t5_load", 8'hFF);
        jtag_stream("t5_strm");
        check("t5_wrap", dut.jtag_addr_q, 8'h00);
        strobe(1, '0);
        strobe(2, jdo_b(32'h55AA55AA));
        check("t5_err_set", monitor_error, 1'b1);
        wait_ready("t5_drop", n);
        check("t5_drop_mon", MonDReg, mdl[mja]);
        mja++;
        check("t5_drop_jaddr", dut.jtag_addr_q, mja);
        check("t5_drop_ram", ram[mja], mdl[mja]);

        // Strobe accepted in the completion cycle of the previous write.
        strobe(2, jdo_b(32'h11112222));
        strobe(2, jdo_b(32'h33334444));
        check("t5_chain_busy", monitor_ready, 1'b0);
        wait_ready("t5_chain", n);
        mdl[mja] = 32'h11112222;
        check("t5_chain_ram0", ram[mja], mdl[mja]);
        mja++;
        mdl[mja] = 32'h33334444;
        check("t5_chain_ram1", ram[mja], mdl[mja]);
        mja++;
        check("t5_err_sticky", monitor_error, 1'b1);
        jtag_load("t5_clr", 8'h40);
        check("t5_err_clr", monitor_error, 1'b0);

        // Reset in the middle of a CPU write.
        strobe(1, '0);
        strobe(1, '0);
        wait_ready("t6_pre", n);
        check("t6_err_pre", monitor_error, 1'b1);
        jtag_read_a("t6_pre2", 8'h50);
        check("t6_mon_pre", MonDReg, mdl[8'h50]);
        cpu_address = 8'h30; cpu_writedata = ~mdl[8'h30]; cpu_byteenable = 4'hF; cpu_write = 1'b1;
        tick();
        check("t6_we_access", ram_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_we", {ram_we, ram_re}, 2'b00);
        check("t6_rst_waitreq", cpu_waitrequest, 1'b1);
        check("t6_rst_ready", monitor_ready, 1'b1);
        check("t6_rst_err", monitor_error, 1'b0);
        check("t6_rst_mon", MonDReg, 32'h0);
        cpu_write = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("t6_ram_kept", ram[8'h30], mdl[8'h30]);
        check("t6_jaddr", dut.jtag_addr_q, 8'h00);
        mja = 8'h00;

        // Contention right after reset: last grant is CPU, so JTAG goes first.
        a = mja;
        cpu_address = a; cpu_read = 1'b1; cpu_byteenable = 4'hF;
        strobe(2, jdo_b(32'hFEEDFACE));
        n = 1;
        while (cpu_waitrequest && n < 20) begin tick(); n++; end
        check("t4_cpu_lat", n, 4);
        check("t4_cpu_new", cpu_readdata, 32'hFEEDFACE);
        tick();
        cpu_read = 1'b0;
        mdl[a] = 32'hFEEDFACE;
        check("t4_ram", ram[a], mdl[a]);
        check("t4_ready", monitor_ready, 1'b1);
        mja++;

        // Randomized sequence against the reference memory.
        for (int it = 0; it < 80; it++) begin
            a = 8'($urandom);
            v = $urandom;
            case ($urandom_range(0, 5))
                0: jtag_read_a("rnd_rda", a);
                1: jtag_stream("rnd_strm");
                2: jtag_write("rnd_wr", v);
                3: cpu_access("rnd_crd", 1'b0, a, 32'h0, 4'hF, 2);
                4: cpu_access("rnd_cwr", 1'b1, a, v, 4'($urandom), 1);
                default: jtag_load("rnd_load", a);
            endcase
        end
        check("rnd_err", monitor_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
